// File: rtl/mix_trace_buffer_if.sv
// Readout stream of the MIX trace buffer: one snapshot word per transfer,
// with a marker on the final word of the captured window.
interface mix_trace_buffer_if #(
    parameter int DATA_W = 86
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/mix_trace_buffer.sv
// MIX trace capture unit: records {pc, rA, rX, rJ} per committed instruction
// into a circular buffer, stops a programmable number of samples after a
// PC-match or forced trigger, then streams the window out oldest first.
module mix_trace_buffer #(
    parameter int DEPTH = 64,
    parameter int PC_W  = 12,
    parameter int REG_W = 31,
    localparam int AW     = $clog2(DEPTH),
    localparam int DATA_W = 2*PC_W + 2*REG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               sample,
    input  logic [PC_W-1:0]    pc,
    input  logic [REG_W-1:0]   reg_a,
    input  logic [REG_W-1:0]   reg_x,
    input  logic [PC_W-1:0]    reg_j,
    input  logic               trig_en,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic               force_trig,
    input  logic [AW-1:0]      post_count,
    mix_trace_buffer_if.master stream,
    output logic [1:0]         state,
    output logic [AW:0]        count,
    output logic               wrapped,
    output logic [AW-1:0]      trig_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } st_t;

    // Readout sub-phases inside DONE: first read, present word, wait for ready.
    typedef enum logic [1:0] {
        RD_ISSUE = 2'd0,
        RD_LOAD  = 2'd1,
        RD_WAIT  = 2'd2
    } rd_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    st_t               cur_st;
    st_t               nxt_st;
    rd_t               rd_phase;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     post_latched;
    logic [AW-1:0]     post_left;
    logic [AW:0]       remain;

    logic              capturing;
    logic              store;
    logic              trig_hit;
    logic              xfer;
    logic              last_xfer;
    logic              enter_done;
    logic              rd_en;
    logic [AW:0]       count_nx;
    logic [AW-1:0]     wr_ptr_nx;
    logic              wrapped_nx;
    logic [AW:0]       tail;
    logic [AW-1:0]     trig_calc;

    assign capturing  = (cur_st == ARMED) || (cur_st == POST);
    assign store      = capturing && sample && !arm;
    assign trig_hit   = force_trig || (trig_en && (pc == trig_pc));
    assign xfer       = stream.valid && stream.ready;
    assign last_xfer  = xfer && stream.last;
    assign enter_done = store && (nxt_st == DONE);

    // Values the capture registers take after the current store.
    assign count_nx   = (count == DEPTH_C) ? count : count + 1'b1;
    assign wr_ptr_nx  = wr_ptr + 1'b1;
    assign wrapped_nx = wrapped || (count == DEPTH_C);

    // Trigger entry sits post_latched words before the newest one; clamp at 0.
    assign tail      = count_nx - 1'b1;
    assign trig_calc = (tail >= {1'b0, post_latched}) ? (tail[AW-1:0] - post_latched) : '0;

    assign rd_en = (cur_st == DONE) && !arm && ((rd_phase == RD_ISSUE) || (rd_phase == RD_LOAD));

    assign state = cur_st;

    // Capture/readout state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_st <= IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Next-state: arm overrides everything, then trigger / post window / readout end.
    always_comb begin
        nxt_st = cur_st;
        if (arm) begin
            nxt_st = ARMED;
        end else begin
            case (cur_st)
                ARMED: if (store && trig_hit) nxt_st = (post_latched == '0) ? DONE : POST;
                POST:  if (store && (post_left == AW'(1))) nxt_st = DONE;
                DONE:  if (last_xfer) nxt_st = IDLE;
                default: nxt_st = cur_st;
            endcase
        end
    end

    // Snapshot storage; write port only, no reset on the array.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= {pc, reg_a, reg_x, reg_j};
        end
    end

    // Synchronous RAM read feeding the output word register.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_ptr];
        end
    end

    // Pointers, fill level, trigger bookkeeping and the output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wrapped      <= 1'b0;
            trig_index   <= '0;
            post_latched <= '0;
            post_left    <= '0;
            remain       <= '0;
            rd_phase     <= RD_ISSUE;
            stream.valid <= 1'b0;
            stream.last  <= 1'b0;
            stream.data  <= '0;
        end else if (arm) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wrapped      <= 1'b0;
            trig_index   <= '0;
            post_latched <= post_count;
            post_left    <= post_count;
            remain       <= '0;
            rd_phase     <= RD_ISSUE;
            stream.valid <= 1'b0;
            stream.last  <= 1'b0;
        end else begin
            if (store) begin
                wr_ptr  <= wr_ptr_nx;
                count   <= count_nx;
                wrapped <= wrapped_nx;
                if (cur_st == POST) begin
                    post_left <= post_left - 1'b1;
                end
            end
            if (enter_done) begin
                trig_index <= trig_calc;
                rd_ptr     <= wrapped_nx ? wr_ptr_nx : '0;
                remain     <= count_nx;
                rd_phase   <= RD_ISSUE;
            end else if (cur_st == DONE) begin
                case (rd_phase)
                    RD_ISSUE: begin
                        rd_ptr   <= rd_ptr + 1'b1;
                        rd_phase <= RD_LOAD;
                    end
                    RD_LOAD: begin
                        // Present the fetched word and prefetch the next one.
                        stream.data  <= rd_data;
                        stream.valid <= 1'b1;
                        stream.last  <= (remain == ONE_C);
                        rd_ptr       <= rd_ptr + 1'b1;
                        rd_phase     <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (xfer) begin
                            stream.valid <= 1'b0;
                            stream.last  <= 1'b0;
                            remain       <= remain - 1'b1;
                            rd_phase     <= RD_LOAD;
                        end
                    end
                    default: rd_phase <= RD_ISSUE;
                endcase
            end
        end
    end

endmodule
